el2_lsu_dccm_wrbuf: RTL and testbench
=====================================

# el2_lsu_dccm_wrbuf

DCCM store write buffer sitting directly upstream of the single-ported DCCM memory banks. It absorbs committed stores (already merged and ECC-encoded, lo/hi halves for bank-unaligned accesses) into a small FIFO. It drains them to the DCCM write port in cycles the load path does not need the array, and arbitrates the DCCM read enable. It also forwards buffered data to loads that hit a pending entry, so loads never observe stale array data.

## Interface
Parameters:
- DEPTH, 4, number of buffer entries (power of 2, ≥2)
- DCCM_BITS, 16, DCCM byte-address width
- DCCM_FDATA_WIDTH, 39, data+ECC width per half

Ports:
- clk  in  1  core clock (active clock domain)
- rst_l  in  1  reset, asynchronous, active-low
- st_valid  in  1  committed store presented
- st_ready  out  1  buffer can accept store this cycle
- st_addr_lo / st_addr_hi  in  DCCM_BITS  store addresses (equal bank bits ⇒ aligned)
- st_data_lo / st_data_hi  in  DCCM_FDATA_WIDTH  store data
- ld_rden  in  1  load requests DCCM read
- ld_addr_lo / ld_addr_hi  in  DCCM_BITS  load addresses
- ld_stall  out  1  load must retry next cycle
- fwd_hit_lo / fwd_hit_hi  out  1  load half satisfied from buffer
- fwd_data_lo / fwd_data_hi  out  DCCM_FDATA_WIDTH  forwarded data
- dccm_wren / dccm_rden  out  1  to DCCM memory
- dccm_wr_addr_lo / dccm_wr_addr_hi  out  DCCM_BITS
- dccm_wr_data_lo / dccm_wr_data_hi  out  DCCM_FDATA_WIDTH
- wrbuf_empty  out  1  no pending entries

## Operation
- Circular FIFO: wr_ptr, rd_ptr (log2 DEPTH bits, wrap), count (log2 DEPTH + 1 bits).
- Enqueue: st_valid & st_ready; st_ready = (count != DEPTH). Entry holds addr_lo/hi and data_lo/hi.
- Match: entry matches a load half when ld_addr[DCCM_BITS-1:2] equals entry addr_lo[DCCM_BITS-1:2] (supplies data_lo) or addr_hi[DCCM_BITS-1:2] (supplies data_hi). The youngest matching entry wins. Matching is evaluated for lo and hi load halves independently.
- Drain (dccm_wren=1, head entry on dccm_wr_*) when count≠0 and any of:
  - ~ld_rden
  - count==DEPTH
  - forwarding absent and load matches any entry
- dccm_rden = ld_rden & ~drain.
- ld_stall = ld_rden & drain.
- rd_ptr advances on drain. Enqueue and drain in the same cycle leave count unchanged.
- The head entry is drainable the cycle after it is written. There is no same-cycle bypass from the st_* inputs to dccm_wr_*.

## Timing
- Reset values:
  - count=0, pointers=0, storage=0
  - st_ready=1, wrbuf_empty=1
  - dccm_wren=0, dccm_rden=0, ld_stall=0
  - fwd_hit_*=0, all data/addr outputs 0
- dccm_wr_*, dccm_rden, ld_stall and fwd_* are combinational from state and inputs. The DCCM samples them at the next clk edge.
- Minimum store-to-array latency: 2 edges (enqueue edge, drain edge).
- Full and a load in the same cycle: the drain wins, ld_stall=1, and st_ready=0 for that cycle.
- Full: st_valid is ignored while st_ready=0. The upstream stage must hold the store.
- Wrap-around: pointers wrap from DEPTH-1 to 0. The full/empty distinction comes from count, not pointer equality.
- Reset mid-operation: all pending entries are discarded immediately and outputs return to reset values asynchronously.

## Configuration
- EL2_DCCM_WRBUF_FWD_EN defined:
  - fwd_hit_*/fwd_data_* are driven from matching entries.
  - A load hitting the buffer proceeds without stall unless a drain is forced by full.
- Undefined:
  - fwd_hit_*=0 and fwd_data_*=0 are tied off.
  - A load matching any entry forces a drain each cycle, with ld_stall=1, until no entry matches.
  - The match logic is kept only for this hazard detection.

## Structure
- The shared LSU package holds the entry typedef el2_wrbuf_entry_t {addr_lo, addr_hi, data_lo, data_hi}, plus the DEPTH default and pointer-width constants.
- One sub-module, el2_lsu_wrbuf_match: per-entry address compare plus youngest-first priority select. It is reused for both the forwarding and the hazard paths.
- Storage uses rvdffe-style flops enabled per entry on enqueue. Pointers and count use async-reset flops.

## Test plan
- Reset, then st_valid with addr_lo=addr_hi=0x0010, data_lo=0x12 and ld_rden=0 → st_ready=1 on that edge. Next cycle dccm_wren=1, dccm_wr_addr_lo=0x0010. Cycle after, wrbuf_empty=1.
- Fill 4 stores with ld_rden=1 held → st_ready=0 after the 4th. Next cycle dccm_wren=1, ld_stall=1, count becomes 3, st_ready=1.
- With FWD_EN: store 0x0020 data 0xAA, then store 0x0020 data 0xBB, then load 0x0022 → fwd_hit_lo=1, fwd_data_lo=0xBB, ld_stall=0.
- Without FWD_EN, same sequence → ld_stall=1 for 2 cycles (both entries drained), then dccm_rden=1, fwd_hit_lo=0.
- Unaligned store lo=0x003C, hi=0x0040 → one drain with wr_addr_lo=0x003C, wr_addr_hi=0x0040. A load at 0x0040 forwards data_hi.
- Assert rst_l low while count=3 → count=0, dccm_wren=0 asynchronously. After release, no drains occur.

Source files
------------

// File: rtl/el2_lsu_dccm_wrbuf_pkg.sv
// Shared LSU write-buffer types: the buffered entry layout plus depth and pointer constants.
// Entry field widths follow WRBUF_ADDR_W/WRBUF_DATA_W; DCCM_BITS/DCCM_FDATA_WIDTH must be overridden together with them.
package el2_lsu_dccm_wrbuf_pkg;

    localparam int WRBUF_DEPTH  = 4;
    localparam int WRBUF_PTR_W  = $clog2(WRBUF_DEPTH);
    localparam int WRBUF_CNT_W  = WRBUF_PTR_W + 1;
    localparam int WRBUF_ADDR_W = 16;
    localparam int WRBUF_DATA_W = 39;

    typedef struct packed {
        logic [WRBUF_ADDR_W-1:0] addr_lo;
        logic [WRBUF_ADDR_W-1:0] addr_hi;
        logic [WRBUF_DATA_W-1:0] data_lo;
        logic [WRBUF_DATA_W-1:0] data_hi;
    } el2_wrbuf_entry_t;

endpackage

// File: rtl/el2_lsu_wrbuf_match.sv
// Word-address match of one load half against all pending entries; youngest matching entry wins.
// Used both to forward data and to detect load/store hazards.
module el2_lsu_wrbuf_match
    import el2_lsu_dccm_wrbuf_pkg::*;
#(
    parameter int DEPTH            = WRBUF_DEPTH,
    parameter int DCCM_BITS        = WRBUF_ADDR_W,
    parameter int DCCM_FDATA_WIDTH = WRBUF_DATA_W,
    parameter int PTR_W            = $clog2(DEPTH)
) (
    input  el2_wrbuf_entry_t              entries [DEPTH],
    input  logic [PTR_W-1:0]              rd_ptr,
    input  logic [PTR_W:0]                count,
    input  logic [DCCM_BITS-1:0]          ld_addr,
    output logic                          hit,
    output logic [DCCM_FDATA_WIDTH-1:0]   data
);

    logic [PTR_W-1:0] idx;
    logic             unused_addr_lsb;

    // Walk oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        hit             = 1'b0;
        data            = '0;
        idx             = '0;
        unused_addr_lsb = ^ld_addr[1:0];
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            unused_addr_lsb = unused_addr_lsb ^ (^entries[i].addr_lo[1:0]) ^ (^entries[i].addr_hi[1:0]);
            if ((PTR_W+1)'(i) < count) begin
                if (entries[idx].addr_lo[DCCM_BITS-1:2] == ld_addr[DCCM_BITS-1:2]) begin
                    hit  = 1'b1;
                    data = entries[idx].data_lo;
                end else if (entries[idx].addr_hi[DCCM_BITS-1:2] == ld_addr[DCCM_BITS-1:2]) begin
                    hit  = 1'b1;
                    data = entries[idx].data_hi;
                end
            end
        end
    end

endmodule

// File: rtl/el2_lsu_dccm_wrbuf.sv
// DCCM store write buffer: FIFO of committed stores drained into the DCCM when loads leave the port idle.
// Store-to-load forwarding is enabled by defining EL2_DCCM_WRBUF_FWD_EN; otherwise matching loads stall until drained.
module el2_lsu_dccm_wrbuf
    import el2_lsu_dccm_wrbuf_pkg::*;
#(
    parameter int DEPTH            = WRBUF_DEPTH,
    parameter int DCCM_BITS        = WRBUF_ADDR_W,
    parameter int DCCM_FDATA_WIDTH = WRBUF_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        st_valid,
    output logic                        st_ready,
    input  logic [DCCM_BITS-1:0]        st_addr_lo,
    input  logic [DCCM_BITS-1:0]        st_addr_hi,
    input  logic [DCCM_FDATA_WIDTH-1:0] st_data_lo,
    input  logic [DCCM_FDATA_WIDTH-1:0] st_data_hi,
    input  logic                        ld_rden,
    input  logic [DCCM_BITS-1:0]        ld_addr_lo,
    input  logic [DCCM_BITS-1:0]        ld_addr_hi,
    output logic                        ld_stall,
    output logic                        fwd_hit_lo,
    output logic                        fwd_hit_hi,
    output logic [DCCM_FDATA_WIDTH-1:0] fwd_data_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] fwd_data_hi,
    output logic                        dccm_wren,
    output logic                        dccm_rden,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi,
    output logic                        wrbuf_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    el2_wrbuf_entry_t            entries [DEPTH];
    el2_wrbuf_entry_t            head;
    logic [PTR_W-1:0]            wr_ptr, rd_ptr;
    logic [PTR_W:0]              count;
    logic                        full, enq, drain, hazard;
    logic                        hit_lo, hit_hi;
    logic [DCCM_FDATA_WIDTH-1:0] match_lo, match_hi;

    assign full        = (count == (PTR_W+1)'(DEPTH));
    assign st_ready    = ~full;
    assign enq         = st_valid & st_ready;
    assign wrbuf_empty = (count == '0);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int e = 0; e < DEPTH; e++) entries[e] <= '0;
        end else if (enq) begin
            entries[wr_ptr] <= '{addr_lo: st_addr_lo, addr_hi: st_addr_hi,
                                 data_lo: st_data_lo, data_hi: st_data_hi};
        end
    end

    // Full/empty is tracked by count; pointers are free-running and wrap.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)   wr_ptr <= wr_ptr + 1'b1;
            if (drain) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    el2_lsu_wrbuf_match #(.DEPTH(DEPTH), .DCCM_BITS(DCCM_BITS), .DCCM_FDATA_WIDTH(DCCM_FDATA_WIDTH)) match_lo_i (
        .entries(entries), .rd_ptr(rd_ptr), .count(count), .ld_addr(ld_addr_lo),
        .hit(hit_lo), .data(match_lo)
    );

    el2_lsu_wrbuf_match #(.DEPTH(DEPTH), .DCCM_BITS(DCCM_BITS), .DCCM_FDATA_WIDTH(DCCM_FDATA_WIDTH)) match_hi_i (
        .entries(entries), .rd_ptr(rd_ptr), .count(count), .ld_addr(ld_addr_hi),
        .hit(hit_hi), .data(match_hi)
    );

`ifdef EL2_DCCM_WRBUF_FWD_EN
    assign hazard      = 1'b0;
    assign fwd_hit_lo  = ld_rden & hit_lo;
    assign fwd_hit_hi  = ld_rden & hit_hi;
    assign fwd_data_lo = fwd_hit_lo ? match_lo : '0;
    assign fwd_data_hi = fwd_hit_hi ? match_hi : '0;
`else
    logic unused_match_data;
    assign unused_match_data = ^{match_lo, match_hi};
    assign hazard      = ld_rden & (hit_lo | hit_hi);
    assign fwd_hit_lo  = 1'b0;
    assign fwd_hit_hi  = 1'b0;
    assign fwd_data_lo = '0;
    assign fwd_data_hi = '0;
`endif

    // A full buffer or a stale-data hazard takes the port away from the load.
    assign drain     = (count != '0) & (~ld_rden | full | hazard);
    assign head      = entries[rd_ptr];
    assign dccm_wren = drain;
    assign dccm_rden = ld_rden & ~drain;
    assign ld_stall  = ld_rden & drain;

    assign dccm_wr_addr_lo = drain ? head.addr_lo : '0;
    assign dccm_wr_addr_hi = drain ? head.addr_hi : '0;
    assign dccm_wr_data_lo = drain ? head.data_lo : '0;
    assign dccm_wr_data_hi = drain ? head.data_hi : '0;

endmodule

// File: tb/tb_el2_lsu_dccm_wrbuf.sv
// Scoreboard bench for el2_lsu_dccm_wrbuf: accepted stores queue expected DCCM writes, a monitor checks each drain.
// Directed checks cover handshake, stall, forwarding (EL2_DCCM_WRBUF_FWD_EN) and asynchronous reset.
module tb_el2_lsu_dccm_wrbuf;

    logic        clk, rst_l;
    logic        st_valid, st_ready;
    logic [15:0] st_addr_lo, st_addr_hi;
    logic [38:0] st_data_lo, st_data_hi;
    logic        ld_rden, ld_stall;
    logic [15:0] ld_addr_lo, ld_addr_hi;
    logic        fwd_hit_lo, fwd_hit_hi;
    logic [38:0] fwd_data_lo, fwd_data_hi;
    logic        dccm_wren, dccm_rden;
    logic [15:0] dccm_wr_addr_lo, dccm_wr_addr_hi;
    logic [38:0] dccm_wr_data_lo, dccm_wr_data_hi;
    logic        wrbuf_empty;

    int errors = 0;
    int checks = 0;
    logic [109:0] sb [$];

    el2_lsu_dccm_wrbuf dut (
        .clk(clk), .rst_l(rst_l),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr_lo(st_addr_lo), .st_addr_hi(st_addr_hi),
        .st_data_lo(st_data_lo), .st_data_hi(st_data_hi),
        .ld_rden(ld_rden), .ld_addr_lo(ld_addr_lo), .ld_addr_hi(ld_addr_hi),
        .ld_stall(ld_stall),
        .fwd_hit_lo(fwd_hit_lo), .fwd_hit_hi(fwd_hit_hi),
        .fwd_data_lo(fwd_data_lo), .fwd_data_hi(fwd_data_hi),
        .dccm_wren(dccm_wren), .dccm_rden(dccm_rden),
        .dccm_wr_addr_lo(dccm_wr_addr_lo), .dccm_wr_addr_hi(dccm_wr_addr_hi),
        .dccm_wr_data_lo(dccm_wr_data_lo), .dccm_wr_data_hi(dccm_wr_data_hi),
        .wrbuf_empty(wrbuf_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input logic [15:0] al, input logic [15:0] ah,
                            input logic [38:0] dl, input logic [38:0] dh);
        st_valid   = 1'b1;
        st_addr_lo = al;
        st_addr_hi = ah;
        st_data_lo = dl;
        st_data_hi = dh;
    endtask

    task automatic sb_push();
        sb.push_back({st_addr_lo, st_addr_hi, st_data_lo, st_data_hi});
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        @(negedge clk);
        while (!wrbuf_empty && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk(name, wrbuf_empty, 1'b1);
        step();
    endtask

    // Drain monitor: every DCCM write must match the oldest outstanding accepted store.
    always @(negedge clk) begin
        if (rst_l && dccm_wren) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL drain_unexpected: got write addr_lo=%0h, none expected", dccm_wr_addr_lo);
            end else begin
                chk("drain_entry", {dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_wr_data_lo, dccm_wr_data_hi},
                    sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_l = 1'b0;
        st_valid = 1'b0; st_addr_lo = '0; st_addr_hi = '0; st_data_lo = '0; st_data_hi = '0;
        ld_rden = 1'b0; ld_addr_lo = '0; ld_addr_hi = '0;
        #3;
        chk("rst_st_ready", st_ready, 1'b1);
        chk("rst_empty", wrbuf_empty, 1'b1);
        chk("rst_wren", dccm_wren, 1'b0);
        chk("rst_rden", dccm_rden, 1'b0);
        chk("rst_stall", ld_stall, 1'b0);
        chk("rst_fwd", {fwd_hit_lo, fwd_hit_hi, fwd_data_lo, fwd_data_hi}, '0);
        chk("rst_wr_out", {dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_wr_data_lo, dccm_wr_data_hi}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        step();

        // Single store, port idle: written one edge later, then empty.
        drive_st(16'h0010, 16'h0010, 39'h12, 39'h34);
        @(negedge clk);
        chk("t1_st_ready", st_ready, 1'b1);
        chk("t1_no_bypass", dccm_wren, 1'b0);
        sb_push();
        step();
        st_valid = 1'b0;
        @(negedge clk);
        chk("t1_wren", dccm_wren, 1'b1);
        chk("t1_wr_addr_lo", dccm_wr_addr_lo, 16'h0010);
        step();
        @(negedge clk);
        chk("t1_empty", wrbuf_empty, 1'b1);
        chk("t1_wren_off", dccm_wren, 1'b0);
        step();

        // Fill under continuous non-matching loads, then full forces a drain.
        ld_rden = 1'b1; ld_addr_lo = 16'h0100; ld_addr_hi = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            drive_st(16'h0200 + 16'(4*i), 16'h0200 + 16'(4*i), 39'(i+1), 39'(i+17));
            @(negedge clk);
            chk("t2_fill_ready", st_ready, 1'b1);
            chk("t2_fill_rden", dccm_rden, 1'b1);
            chk("t2_fill_stall", ld_stall, 1'b0);
            sb_push();
            step();
        end
        drive_st(16'h0210, 16'h0210, 39'h5, 39'h15);
        @(negedge clk);
        chk("t2_full_ready", st_ready, 1'b0);
        chk("t2_full_wren", dccm_wren, 1'b1);
        chk("t2_full_stall", ld_stall, 1'b1);
        chk("t2_full_rden", dccm_rden, 1'b0);
        step();
        @(negedge clk);
        chk("t2_cnt3_ready", st_ready, 1'b1);
        chk("t2_cnt3_wren", dccm_wren, 1'b0);
        chk("t2_cnt3_stall", ld_stall, 1'b0);
        sb_push();
        step();
        st_valid = 1'b0;
        @(negedge clk);
        chk("t2_refull_stall", ld_stall, 1'b1);
        chk("t2_refull_ready", st_ready, 1'b0);
        step();
        ld_rden = 1'b0;
        wait_empty("t2_empty");

        // Two stores to the same word, then a load of that word.
        ld_rden = 1'b1; ld_addr_lo = 16'h0100; ld_addr_hi = 16'h0100;
        drive_st(16'h0020, 16'h0020, 39'hAA, 39'hA5);
        @(negedge clk);
        sb_push();
        step();
        drive_st(16'h0020, 16'h0020, 39'hBB, 39'hB5);
        @(negedge clk);
        sb_push();
        step();
        st_valid = 1'b0; ld_addr_lo = 16'h0022; ld_addr_hi = 16'h0022;
`ifdef EL2_DCCM_WRBUF_FWD_EN
        @(negedge clk);
        chk("t3_fwd_hit_lo", fwd_hit_lo, 1'b1);
        chk("t3_fwd_data_lo", fwd_data_lo, 39'hBB);
        chk("t3_stall", ld_stall, 1'b0);
        chk("t3_rden", dccm_rden, 1'b1);
        step();
`else
        @(negedge clk);
        chk("t3_stall_0", ld_stall, 1'b1);
        chk("t3_wren_0", dccm_wren, 1'b1);
        chk("t3_fwd_off", fwd_hit_lo, 1'b0);
        step();
        @(negedge clk);
        chk("t3_stall_1", ld_stall, 1'b1);
        chk("t3_wren_1", dccm_wren, 1'b1);
        step();
        @(negedge clk);
        chk("t3_stall_done", ld_stall, 1'b0);
        chk("t3_rden", dccm_rden, 1'b1);
        chk("t3_fwd_hit_lo", fwd_hit_lo, 1'b0);
        step();
`endif
        ld_rden = 1'b0;
        wait_empty("t3_empty");

        // Bank-unaligned store; load of the upper word.
        ld_rden = 1'b1; ld_addr_lo = 16'h0100; ld_addr_hi = 16'h0100;
        drive_st(16'h003C, 16'h0040, 39'h3C3C, 39'h4040);
        @(negedge clk);
        sb_push();
        step();
        st_valid = 1'b0; ld_addr_lo = 16'h0040; ld_addr_hi = 16'h0044;
`ifdef EL2_DCCM_WRBUF_FWD_EN
        @(negedge clk);
        chk("t4_fwd_hit_lo", fwd_hit_lo, 1'b1);
        chk("t4_fwd_data_lo", fwd_data_lo, 39'h4040);
        chk("t4_fwd_hit_hi", fwd_hit_hi, 1'b0);
        chk("t4_stall", ld_stall, 1'b0);
        step();
        ld_rden = 1'b0;
        @(negedge clk);
        chk("t4_wr_addrs", {dccm_wren, dccm_wr_addr_lo, dccm_wr_addr_hi}, {1'b1, 16'h003C, 16'h0040});
        step();
`else
        @(negedge clk);
        chk("t4_stall", ld_stall, 1'b1);
        chk("t4_wr_addrs", {dccm_wren, dccm_wr_addr_lo, dccm_wr_addr_hi}, {1'b1, 16'h003C, 16'h0040});
        step();
        @(negedge clk);
        chk("t4_stall_done", ld_stall, 1'b0);
        chk("t4_rden", dccm_rden, 1'b1);
        step();
`endif
        ld_rden = 1'b0;
        wait_empty("t4_empty");

        // Asynchronous reset with three entries pending.
        ld_rden = 1'b1; ld_addr_lo = 16'h0100; ld_addr_hi = 16'h0100;
        for (int i = 0; i < 3; i++) begin
            drive_st(16'h0300 + 16'(4*i), 16'h0300 + 16'(4*i), 39'(8'h70 + i), 39'h0);
            @(negedge clk);
            sb_push();
            step();
        end
        st_valid = 1'b0; ld_rden = 1'b0;
        #2;
        chk("t5_pre_wren", dccm_wren, 1'b1);
        sb.delete();
        rst_l = 1'b0;
        #1;
        chk("t5_rst_wren", dccm_wren, 1'b0);
        chk("t5_rst_empty", wrbuf_empty, 1'b1);
        chk("t5_rst_ready", st_ready, 1'b1);
        chk("t5_rst_wr_addr", dccm_wr_addr_lo, 16'h0);
        #3;
        rst_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_drain", dccm_wren, 1'b0);
            chk("t5_still_empty", wrbuf_empty, 1'b1);
        end

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
